// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes,
// FSM states and the natural-alignment rule.
package dmem_pkg;

    localparam int DEFAULT_MEM_AW = 16;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } sizeT;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        CAP   = 3'd3,
        WR_LO = 3'd4,
        WR_HI = 3'd5,
        RSP   = 3'd6,
        ERR   = 3'd7
    } stateT;

    // Natural alignment: an access of 2^n bytes needs the low n address bits clear.
    function automatic logic isAligned(input sizeT size, input logic [2:0] addrLow);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (addrLow[0] == 1'b0);
            SZ_W:    ok = (addrLow[1:0] == 2'b00);
            default: ok = (addrLow == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-side request/response bus of the data-memory responder.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is high only while the responder is idle.
// The response is a single-cycle rsp_valid pulse; rsp_rdata/rsp_err are
// meaningful while it is high and hold their value until the next response.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder_lane_merge.sv
// Combinational byte-lane logic: pulls a zero-extended byte/half/word out of a
// memory word, and inserts new store data into a word leaving other bytes intact.
module lane_merge
    import dmem_pkg::*;
(
    input  logic [31:0] oldWord,
    input  logic [31:0] newData,
    input  sizeT        size,
    input  logic [1:0]  offset,
    output logic [31:0] extractVal,
    output logic [31:0] mergedWord
);

    // Extract the addressed lane, zero-extended; sign extension is the core's job.
    always_comb begin
        extractVal = 32'd0;
        case (size)
            SZ_B:    extractVal = {24'd0, oldWord[{offset, 3'b000} +: 8]};
            SZ_H:    extractVal = {16'd0, oldWord[{offset[1], 4'b0000} +: 16]};
            default: extractVal = oldWord;
        endcase
    end

    // Overwrite only the addressed lane of the old word with the low store bits.
    always_comb begin
        mergedWord = oldWord;
        case (size)
            SZ_B:    mergedWord[{offset, 3'b000} +: 8]    = newData[7:0];
            SZ_H:    mergedWord[{offset[1], 4'b0000} +: 16] = newData[15:0];
            default: mergedWord = newData;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data port. Runs one load/store at a
// time against a 32-bit synchronous-read memory: doublewords become two word
// accesses, sub-word stores become read-modify-write.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_AW = DEFAULT_MEM_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    output logic [MEM_AW-1:0]    mem_raddr,
    input  logic [31:0]          mem_rdata,
    output logic [MEM_AW-1:0]    mem_waddr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_wr,
    output stateT                dbgState
);

    stateT              stateQ, stateD;
    logic               reqWriteQ;
    sizeT               reqSizeQ;
    logic [MEM_AW+1:0]  addrQ;
    logic [63:0]        wdataQ;
    logic [31:0]        loWordQ;
    logic [31:0]        mergedQ;
    logic [63:0]        rspRdataQ;
    logic               rspErrQ;

    logic               accept;
    sizeT               inSize;
    logic               inAligned;
    logic [MEM_AW-1:0]  wordIdx;
    logic [MEM_AW-1:0]  wordIdxHi;
    logic [31:0]        extractVal;
    logic [31:0]        mergedWord;
    logic [63:0]        loadResult;
    logic               unusedAddrBits;

    assign inSize    = sizeT'(bus.req_size);
    assign inAligned = isAligned(inSize, bus.req_addr[2:0]);
    assign accept    = (stateQ == IDLE) && bus.req_valid;

    // Address bits above the memory size are ignored, so accesses wrap.
    assign unusedAddrBits = ^bus.req_addr[63:MEM_AW+2];

    assign wordIdx   = addrQ[MEM_AW+1:2];
    assign wordIdxHi = wordIdx + {{(MEM_AW-1){1'b0}}, 1'b1};

    lane_merge u_lane_merge (
        .oldWord    (mem_rdata),
        .newData    (wdataQ[31:0]),
        .size       (reqSizeQ),
        .offset     (addrQ[1:0]),
        .extractVal (extractVal),
        .mergedWord (mergedWord)
    );

    // Doubleword loads combine the earlier low word with the word arriving now.
    assign loadResult = (reqSizeQ == SZ_D) ? {mem_rdata, loWordQ} : {32'd0, extractVal};

    // State register plus captured request, read data and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= IDLE;
            reqWriteQ <= 1'b0;
            reqSizeQ  <= SZ_B;
            addrQ     <= '0;
            wdataQ    <= 64'd0;
            loWordQ   <= 32'd0;
            mergedQ   <= 32'd0;
            rspRdataQ <= 64'd0;
            rspErrQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (accept) begin
                reqWriteQ <= bus.req_write;
                reqSizeQ  <= inSize;
                addrQ     <= bus.req_addr[MEM_AW+1:0];
                wdataQ    <= bus.req_wdata;
            end
            if (stateQ == RD_HI) begin
                loWordQ <= mem_rdata;
            end
            if (stateQ == CAP && reqWriteQ) begin
                mergedQ <= mergedWord;
            end
            // Response registers change only when a new response begins.
            if (stateD == RSP) begin
                rspRdataQ <= reqWriteQ ? 64'd0 : loadResult;
                rspErrQ   <= 1'b0;
            end else if (stateD == ERR) begin
                rspRdataQ <= 64'd0;
                rspErrQ   <= 1'b1;
            end
        end
    end

    // Next-state: sequence of read/capture/write steps per request kind.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!inAligned) begin
                        stateD = ERR;
                    end else if (bus.req_write && (inSize == SZ_W || inSize == SZ_D)) begin
                        stateD = WR_LO;
                    end else begin
                        stateD = RD_LO;
                    end
                end
            end
            RD_LO:   stateD = (!reqWriteQ && reqSizeQ == SZ_D) ? RD_HI : CAP;
            RD_HI:   stateD = CAP;
            CAP:     stateD = reqWriteQ ? WR_LO : RSP;
            WR_LO:   stateD = (reqSizeQ == SZ_D) ? WR_HI : RSP;
            WR_HI:   stateD = RSP;
            RSP:     stateD = IDLE;
            ERR:     stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Outputs decoded from state; rst gates strobes so an aborted op has no side effects.
    always_comb begin
        mem_raddr     = '0;
        mem_waddr     = '0;
        mem_wdata     = 32'd0;
        mem_wr        = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (stateQ)
            IDLE:  bus.req_ready = !rst;
            RD_LO: mem_raddr = wordIdx;
            RD_HI: mem_raddr = wordIdxHi;
            WR_LO: begin
                mem_waddr = wordIdx;
                mem_wdata = (reqSizeQ == SZ_B || reqSizeQ == SZ_H) ? mergedQ : wdataQ[31:0];
                mem_wr    = !rst;
            end
            WR_HI: begin
                mem_waddr = wordIdxHi;
                mem_wdata = wdataQ[63:32];
                mem_wr    = !rst;
            end
            RSP:     bus.rsp_valid = !rst;
            ERR:     bus.rsp_valid = !rst;
            default: ;
        endcase
    end

    assign bus.rsp_rdata = rspRdataQ;
    assign bus.rsp_err   = rspErrQ;
    assign dbgState      = stateQ;

endmodule
